// File: rtl/mips_exc_pkg.sv
// -----------------------------------------------------------------------------
// mips_exc_pkg
//   Shared definitions for the exception / interrupt arbiter:
//     - CP0 cause codes emitted on cause_code_out
//     - bit positions of the enable fields inside the CP0 STATUS word
//     - the arbiter FSM state type
//     - lowest_one_hot(): picks the lowest-indexed set bit of a pending vector
// -----------------------------------------------------------------------------
package mips_exc_pkg;

  // Number of hardware interrupt lines handled by the arbiter.
  localparam int NUM_IRQ = 4;

  // Exception codes written to CP0 CAUSE.ExcCode.
  localparam logic [4:0] CAUSE_INT     = 5'd0;
  localparam logic [4:0] CAUSE_SYSCALL = 5'd8;
  localparam logic [4:0] CAUSE_BREAK   = 5'd9;
  localparam logic [4:0] CAUSE_TRAP    = 5'd13;

  // STATUS bit positions.
  localparam int STATUS_IE         = 0;  // global interrupt/exception enable
  localparam int STATUS_SYSCALL_EN = 1;
  localparam int STATUS_BREAK_EN   = 2;
  localparam int STATUS_TEQ_EN     = 3;
  localparam int STATUS_INT_EN     = 4;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    EXC_IDLE    = 2'd0,
    EXC_FIRE    = 2'd1,
    EXC_HANDLER = 2'd2
  } exc_state_t;

  // One-hot mask of the lowest-indexed set bit of vec (all zero if vec == 0).
  function automatic logic [NUM_IRQ-1:0] lowest_one_hot(input logic [NUM_IRQ-1:0] vec);
    logic [NUM_IRQ-1:0] sel;
    sel = '0;
    // Scan from the top down so the last hit (lowest index) wins.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// -----------------------------------------------------------------------------
// irq_sync
//   Per-line conditioning of the asynchronous hardware interrupt lines and
//   rising-edge detection.
//
//   Build option (macro IRQ_SYNC_EN):
//     defined   : irq_in -> 2-flop synchronizer -> edge-detect flop.
//                 A rise on irq_in is reported on rise_out after the second
//                 clock edge, so the pending bit it sets in the arbiter is
//                 visible after the third edge.
//     undefined : irq_in feeds the edge-detect flop directly; the pending bit
//                 is visible after the first edge.
//
//   Ports:
//     clk_in    in   clock
//     reset_in  in   asynchronous active-high reset (clears every flop)
//     irq_in    in   [NUM_IRQ] raw level-high interrupt lines
//     rise_out  out  [NUM_IRQ] combinational one-cycle rising-edge indication
// -----------------------------------------------------------------------------
module irq_sync
  import mips_exc_pkg::*;
(
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [NUM_IRQ-1:0] rise_out
);

  // Level seen by the edge detector (synchronized or raw depending on build).
  logic [NUM_IRQ-1:0] level;

  genvar gi;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] meta_q;
  logic [NUM_IRQ-1:0] meta_d;
  logic [NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] sync_d;

  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
      always_comb begin
        meta_d[gi] = irq_in[gi];
        sync_d[gi] = meta_q[gi];
      end

      always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
          meta_q[gi] <= 1'b0;
          sync_q[gi] <= 1'b0;
        end else begin
          meta_q[gi] <= meta_d[gi];
          sync_q[gi] <= sync_d[gi];
        end
      end
    end
  endgenerate

  assign level = sync_q;
`else
  assign level = irq_in;
`endif

  // Edge detector: remember the previous level and flag 0 -> 1 transitions.
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] prev_d;

  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_edge
      always_comb begin
        prev_d[gi] = level[gi];
      end

      always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
          prev_q[gi] <= 1'b0;
        end else begin
          prev_q[gi] <= prev_d[gi];
        end
      end

      assign rise_out[gi] = level[gi] & ~prev_q[gi];
    end
  endgenerate

endmodule

// File: rtl/irq_exc_arbiter.sv
// -----------------------------------------------------------------------------
// irq_exc_arbiter
//   Arbitrates the synchronous exceptions (SYSCALL, BREAK, TEQ trap) coming
//   from decode and the latched hardware interrupts, and raises a single CP0
//   exception request with its cause code and EPC. Only one exception is
//   handled at a time: once fired, the arbiter waits in HANDLER until ERET.
//
//   FSM: IDLE -> FIRE (one cycle: exc_req_out/flush_out high) -> HANDLER
//        -> IDLE on eret_in.
//   Priority: syscall > break > teq > interrupt.
//
//   Build option: IRQ_SYNC_EN (see irq_sync) adds a 2-flop synchronizer in
//   front of the interrupt edge detector.
//
//   Ports:
//     clk_in           in   clock
//     reset_in         in   asynchronous active-high reset
//     syscall_in       in   SYSCALL decoded (one-cycle pulse)
//     break_in         in   BREAK decoded (one-cycle pulse)
//     teq_in           in   TEQ trap taken (one-cycle pulse)
//     irq_in           in   [4] asynchronous level-high interrupt lines
//     status_in        in   [32] CP0 STATUS ([0] IE, [1] sys, [2] brk,
//                           [3] teq, [4] int enables)
//     pc_in            in   [32] PC of the decode-stage instruction
//     eret_in          in   ERET decoded
//     exc_req_out      out  CP0 exception strobe (one cycle)
//     cause_code_out   out  [5] exception code of the last fired exception
//     epc_out          out  [32] PC captured with the last fired exception
//     flush_out        out  pipeline flush (one cycle, with exc_req_out)
//     in_handler_out   out  high in FIRE and HANDLER
//     irq_pending_out  out  [4] latched interrupt lines
// -----------------------------------------------------------------------------
module irq_exc_arbiter
  import mips_exc_pkg::*;
(
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               syscall_in,
  input  logic               break_in,
  input  logic               teq_in,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [31:0]        status_in,
  input  logic [31:0]        pc_in,
  input  logic               eret_in,
  output logic               exc_req_out,
  output logic [4:0]         cause_code_out,
  output logic [31:0]        epc_out,
  output logic               flush_out,
  output logic               in_handler_out,
  output logic [NUM_IRQ-1:0] irq_pending_out
);

  // ---------------------------------------------------------------------------
  // Interrupt edge detection
  // ---------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] irq_rise;

  irq_sync u_irq_sync (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .irq_in   (irq_in),
    .rise_out (irq_rise)
  );

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  exc_state_t         state_q;
  exc_state_t         state_d;
  logic               exc_req_q;
  logic               exc_req_d;
  logic               flush_q;
  logic               flush_d;
  logic               in_handler_q;
  logic               in_handler_d;
  logic [4:0]         cause_q;
  logic [4:0]         cause_d;
  logic [31:0]        epc_q;
  logic [31:0]        epc_d;
  logic [NUM_IRQ-1:0] irq_pending_q;
  logic [NUM_IRQ-1:0] irq_pending_d;

  // Qualified sources (per-source enable only; global IE applied below).
  logic               src_syscall;
  logic               src_break;
  logic               src_teq;
  logic               src_int;
  logic               take_exc;
  logic [NUM_IRQ-1:0] irq_clear;

  // STATUS bits above the enable field are not used by this block.
  logic unused_status;
  assign unused_status = ^status_in[31:STATUS_INT_EN+1];

  always_comb begin
    src_syscall = syscall_in & status_in[STATUS_SYSCALL_EN];
    src_break   = break_in   & status_in[STATUS_BREAK_EN];
    src_teq     = teq_in     & status_in[STATUS_TEQ_EN];
    src_int     = (|irq_pending_q) & status_in[STATUS_INT_EN];
    take_exc    = status_in[STATUS_IE] &
                  (src_syscall | src_break | src_teq | src_int);

    state_d   = state_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    irq_clear = '0;

    case (state_q)
      EXC_IDLE: begin
        if (take_exc) begin
          state_d = EXC_FIRE;
          epc_d   = pc_in;
          // Highest-priority source wins; lower synchronous pulses that
          // arrive together are simply dropped.
          if (src_syscall) begin
            cause_d = CAUSE_SYSCALL;
          end else if (src_break) begin
            cause_d = CAUSE_BREAK;
          end else if (src_teq) begin
            cause_d = CAUSE_TRAP;
          end else begin
            cause_d   = CAUSE_INT;
            // Service one line per FIRE; the rest stay pending and are
            // picked up after the next ERET.
            irq_clear = lowest_one_hot(irq_pending_q);
          end
        end
      end

      EXC_FIRE: begin
        state_d = EXC_HANDLER;
      end

      EXC_HANDLER: begin
        if (eret_in) begin
          state_d = EXC_IDLE;
        end
      end

      default: begin
        state_d = EXC_IDLE;
      end
    endcase

    // Clear before set: a new rise on the bit being serviced keeps it set.
    irq_pending_d = (irq_pending_q & ~irq_clear) | irq_rise;

    // Outputs are decoded from the next state so they are registered and
    // line up with the state they describe.
    exc_req_d    = (state_d == EXC_FIRE);
    flush_d      = (state_d == EXC_FIRE);
    in_handler_d = (state_d != EXC_IDLE);
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q       <= EXC_IDLE;
      exc_req_q     <= 1'b0;
      flush_q       <= 1'b0;
      in_handler_q  <= 1'b0;
      cause_q       <= '0;
      epc_q         <= '0;
      irq_pending_q <= '0;
    end else begin
      state_q       <= state_d;
      exc_req_q     <= exc_req_d;
      flush_q       <= flush_d;
      in_handler_q  <= in_handler_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  assign exc_req_out     = exc_req_q;
  assign flush_out       = flush_q;
  assign in_handler_out  = in_handler_q;
  assign cause_code_out  = cause_q;
  assign epc_out         = epc_q;
  assign irq_pending_out = irq_pending_q;

endmodule

// File: tb/tb_irq_exc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_irq_exc_arbiter
//   Self-checking bench for irq_exc_arbiter: a table of single-pulse
//   exception vectors, hand-written interrupt / reset sequences, and a
//   randomized run compared against a cycle-level reference model.
//   Honors IRQ_SYNC_EN for the interrupt latency.
// -----------------------------------------------------------------------------
module tb_irq_exc_arbiter;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        syscall_in, break_in, teq_in, eret_in;
  logic [3:0]  irq_in;
  logic [31:0] status_in, pc_in;
  logic        exc_req_out, flush_out, in_handler_out;
  logic [4:0]  cause_code_out;
  logic [31:0] epc_out;
  logic [3:0]  irq_pending_out;

  irq_exc_arbiter dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .syscall_in      (syscall_in),
    .break_in        (break_in),
    .teq_in          (teq_in),
    .irq_in          (irq_in),
    .status_in       (status_in),
    .pc_in           (pc_in),
    .eret_in         (eret_in),
    .exc_req_out     (exc_req_out),
    .cause_code_out  (cause_code_out),
    .epc_out         (epc_out),
    .flush_out       (flush_out),
    .in_handler_out  (in_handler_out),
    .irq_pending_out (irq_pending_out)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: handler occupancy as a mode number, pending interrupts as
  // a plain bit set, and a short history of sampled irq_in values to apply the
  // build-dependent detection delay.
  // ---------------------------------------------------------------------------
  int          m_mode;      // 0 = idle, 1 = firing, 2 = in handler
  logic [3:0]  m_pend;
  logic [4:0]  m_cause;
  logic [31:0] m_epc;
  logic [3:0]  m_hist [0:3]; // m_hist[k] = irq_in sampled k edges ago

  task automatic model_reset();
    m_mode  = 0;
    m_pend  = 4'b0;
    m_cause = 5'd0;
    m_epc   = 32'd0;
    for (int i = 0; i < 4; i++) m_hist[i] = 4'b0;
  endtask

  task automatic model_edge();
    logic [3:0] rise;
    logic [3:0] clr;
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = irq_in;
    rise = m_hist[LAT-1] & ~m_hist[LAT];
    clr  = 4'b0;
    if (m_mode == 0) begin
      if (status_in[0]) begin
        if (syscall_in && status_in[1]) begin
          m_mode = 1; m_cause = 5'd8; m_epc = pc_in;
        end else if (break_in && status_in[2]) begin
          m_mode = 1; m_cause = 5'd9; m_epc = pc_in;
        end else if (teq_in && status_in[3]) begin
          m_mode = 1; m_cause = 5'd13; m_epc = pc_in;
        end else if (m_pend != 4'b0 && status_in[4]) begin
          m_mode = 1; m_cause = 5'd0; m_epc = pc_in;
          for (int i = 0; i < 4; i++) begin
            if (m_pend[i]) begin
              clr = 4'b0001 << i;
              break;
            end
          end
        end
      end
    end else if (m_mode == 1) begin
      m_mode = 2;
    end else if (eret_in) begin
      m_mode = 0;
    end
    m_pend = (m_pend & ~clr) | rise;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".exc_req"},    exc_req_out,     (m_mode == 1));
    chk({tag, ".flush"},      flush_out,       (m_mode == 1));
    chk({tag, ".in_handler"}, in_handler_out,  (m_mode != 0));
    chk({tag, ".cause"},      cause_code_out,  m_cause);
    chk({tag, ".epc"},        epc_out,         m_epc);
    chk({tag, ".pending"},    irq_pending_out, m_pend);
  endtask

  // Advance one clock edge, step the model with the inputs seen at that edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
    model_edge();
  endtask

  task automatic clear_pulses();
    syscall_in = 1'b0;
    break_in   = 1'b0;
    teq_in     = 1'b0;
    eret_in    = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Table of single-pulse exception vectors (applied from IDLE).
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        sc;
    logic        br;
    logic        tq;
    logic [31:0] status;
    logic [31:0] pc;
    logic        exp_req;
    logic [4:0]  exp_cause;
  } vec_t;

  vec_t vecs [0:7];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0003, 32'h0040_0010, 1'b1, 5'd8};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_000F, 32'h0040_0020, 1'b1, 5'd8};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_000F, 32'h0040_0030, 1'b1, 5'd9};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0000_0001, 32'h0040_0040, 1'b0, 5'd0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0000_0009, 32'h0040_0050, 1'b1, 5'd13};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0002, 32'h0040_0060, 1'b0, 5'd0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0000_000B, 32'h0040_0070, 1'b1, 5'd13};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h0000_000E, 32'h0040_0080, 1'b0, 5'd0};
  end

  initial begin
    reset_in  = 1'b1;
    irq_in    = 4'b0;
    status_in = 32'h0;
    pc_in     = 32'h0;
    clear_pulses();
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_all("reset");
    reset_in = 1'b0;

    // ----- table vectors -----
    for (int v = 0; v < 8; v++) begin
      status_in  = vecs[v].status;
      pc_in      = vecs[v].pc;
      syscall_in = vecs[v].sc;
      break_in   = vecs[v].br;
      teq_in     = vecs[v].tq;
      tick();
      $display("[TB] vec %0d sc=%0b br=%0b tq=%0b status=%0h -> req=%0b cause=%0d", v,
               vecs[v].sc, vecs[v].br, vecs[v].tq, vecs[v].status, exc_req_out, cause_code_out);
      chk($sformatf("vec%0d.exc_req", v), exc_req_out, vecs[v].exp_req);
      chk($sformatf("vec%0d.flush", v), flush_out, vecs[v].exp_req);
      if (vecs[v].exp_req) begin
        chk($sformatf("vec%0d.cause", v), cause_code_out, vecs[v].exp_cause);
        chk($sformatf("vec%0d.epc", v), epc_out, vecs[v].pc);
      end
      check_all($sformatf("vec%0d.m", v));
      clear_pulses();
      // Handler phase: no further request may appear, in_handler holds.
      for (int c = 0; c < 4; c++) begin
        tick();
        chk($sformatf("vec%0d.no_second_req", v), exc_req_out, 1'b0);
        chk($sformatf("vec%0d.in_handler", v), in_handler_out, vecs[v].exp_req);
      end
      eret_in = 1'b1;
      tick();
      eret_in = 1'b0;
      chk($sformatf("vec%0d.after_eret", v), in_handler_out, 1'b0);
      check_all($sformatf("vec%0d.idle", v));
    end

    // ----- interrupt on line 2 with synchronizer latency -----
    status_in = 32'h11;
    pc_in     = 32'h0040_1000;
    irq_in    = 4'b0100;
    for (int e = 1; e < LAT; e++) begin
      tick();
      chk("irq2.not_yet_pending", irq_pending_out, 4'b0000);
    end
    tick();
    $display("[TB] irq2 pending after %0d edges = %b", LAT, irq_pending_out);
    chk("irq2.pending", irq_pending_out, 4'b0100);
    chk("irq2.no_req_yet", exc_req_out, 1'b0);
    tick();
    chk("irq2.req", exc_req_out, 1'b1);
    chk("irq2.cause", cause_code_out, 5'd0);
    chk("irq2.cleared", irq_pending_out, 4'b0000);
    check_all("irq2.m");

    // ----- interrupts arriving inside the handler -----
    tick();
    irq_in = 4'b1101;
    repeat (LAT + 1) tick();
    $display("[TB] handler irq pending = %b req=%0b", irq_pending_out, exc_req_out);
    chk("hnd.pending", irq_pending_out, 4'b1001);
    chk("hnd.no_req", exc_req_out, 1'b0);
    chk("hnd.in_handler", in_handler_out, 1'b1);
    eret_in = 1'b1;
    tick();
    eret_in = 1'b0;
    chk("hnd.eret_idle", in_handler_out, 1'b0);
    tick();
    chk("hnd.fire0.req", exc_req_out, 1'b1);
    chk("hnd.fire0.pending", irq_pending_out, 4'b1000);
    tick();
    eret_in = 1'b1;
    tick();
    eret_in = 1'b0;
    tick();
    chk("hnd.fire3.req", exc_req_out, 1'b1);
    chk("hnd.fire3.pending", irq_pending_out, 4'b0000);
    check_all("hnd.m");
    tick();
    eret_in = 1'b1;
    tick();
    eret_in = 1'b0;
    irq_in  = 4'b0000;

    // ----- service a bit while the same bit rises again -----
    status_in = 32'h01;
    irq_in    = 4'b0010;
    repeat (LAT + 1) tick();
    irq_in = 4'b0000;
    repeat (LAT + 1) tick();
    chk("same.pending_before", irq_pending_out, 4'b0010);
    irq_in = 4'b0010;
    for (int e = 1; e < LAT; e++) tick();
    status_in = 32'h11;
    tick();
    $display("[TB] same-bit fire: req=%0b pending=%b", exc_req_out, irq_pending_out);
    chk("same.req", exc_req_out, 1'b1);
    chk("same.pending_kept", irq_pending_out, 4'b0010);
    check_all("same.m");
    status_in = 32'h01;
    tick();
    eret_in = 1'b1;
    tick();
    eret_in = 1'b0;
    irq_in  = 4'b0000;

    // ----- asynchronous reset in the middle of FIRE -----
    status_in  = 32'h03;
    pc_in      = 32'h0040_2000;
    syscall_in = 1'b1;
    tick();
    syscall_in = 1'b0;
    chk("rst.fire", exc_req_out, 1'b1);
    #2;
    reset_in = 1'b1;
    #1;
    $display("[TB] async reset mid-FIRE: req=%0b in_handler=%0b", exc_req_out, in_handler_out);
    chk("rst.exc_req", exc_req_out, 1'b0);
    chk("rst.flush", flush_out, 1'b0);
    chk("rst.in_handler", in_handler_out, 1'b0);
    chk("rst.cause", cause_code_out, 5'd0);
    chk("rst.epc", epc_out, 32'd0);
    chk("rst.pending", irq_pending_out, 4'b0);
    #1;
    reset_in = 1'b0;
    model_reset();
    tick();
    check_all("rst.after");

    // ----- randomized run against the reference model -----
    for (int c = 0; c < 400; c++) begin
      syscall_in = ($urandom_range(0, 5) == 0);
      break_in   = ($urandom_range(0, 5) == 0);
      teq_in     = ($urandom_range(0, 5) == 0);
      eret_in    = ($urandom_range(0, 3) == 0);
      status_in  = {$urandom} & 32'hFFFF_FFE0;
      status_in[4:1] = 4'($urandom_range(0, 15));
      status_in[0]   = ($urandom_range(0, 7) != 0);
      pc_in      = $urandom;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
      end
      if ($urandom_range(0, 99) == 0) begin
        reset_in = 1'b1;
        #1;
        reset_in = 1'b0;
        model_reset();
      end
      tick();
      check_all($sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
